ann_layer_engine: RTL and testbench

// Parametrised fully-connected ANN layer for the drowsiness detector datapath; generalises the fixed 30-5-3 network.

---
 rtl/ann_layer_engine.sv | 202 ++++++++++++++++++++
 tb/tb_ann_layer_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_layer_engine.sv
// ann_layer_engine
// Fully-connected ANN layer: N_OUT neurons, each a weighted sum of N_IN
// unsigned inputs. A single serial MAC produces one product per cycle. Weights
// live in an on-chip RAM. An LFSR fills that RAM on first use or on request.
// The host can overwrite individual weights while the engine is idle.
//
// Ports
//   Clock     rising-edge clock
//   Rst       synchronous reset, active-high
//   Start     evaluation request, sampled only in IDLE
//   Init      with Start: force LFSR weight re-initialisation
//   in_flat   packed inputs, input i at [i*DW +: DW], latched on accepted Start
//   wr_en     host weight write strobe (IDLE only)
//   wr_addr   weight index j*N_IN+i
//   wr_data   signed weight
//   out_flat  packed outputs, neuron j at [j*DW +: DW]
//   Valid     1-cycle pulse, out_flat updated this cycle
//   Busy      high in any state except IDLE
//   state     current FSM state
//
// state | meaning
// IDLE  | waiting for Start; host weight writes accepted
// INIT  | LFSR writes one weight per cycle, address 0..N_IN*N_OUT-1
// MAC   | accumulate one input*weight product per cycle for neuron j
// STORE | shift, activate and buffer the result of neuron j
// DONE  | all neurons published on out_flat, Valid high
module ann_layer_engine #(
  parameter int          N_IN  = 30,
  parameter int          N_OUT = 5,
  parameter int          DW    = 10,
  parameter int          WW    = 8,
  parameter int          FRAC  = 7,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          ACT   = 0
) (
  input  logic                             Clock,
  input  logic                             Rst,
  input  logic                             Start,
  input  logic                             Init,
  input  logic [N_IN*DW-1:0]               in_flat,
  input  logic                             wr_en,
  input  logic [$clog2(N_IN*N_OUT)-1:0]    wr_addr,
  input  logic signed [WW-1:0]             wr_data,
  output logic [N_OUT*DW-1:0]              out_flat,
  output logic                             Valid,
  output logic                             Busy,
  output logic [2:0]                       state
);

  localparam int NW  = N_IN * N_OUT;
  localparam int AWA = $clog2(NW);
  localparam int AW  = DW + WW + $clog2(N_IN) + 1;
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [DW-1:0] Y_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MAC   = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               st;
  logic signed [WW-1:0] wram [NW];
  logic [DW-1:0]        in_reg [N_IN];
  logic [DW-1:0]        res_buf [N_OUT];
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_next;
  logic                 weights_valid;
  logic [AWA-1:0]       w_addr;
  logic [IW-1:0]        i_cnt;
  logic [JW-1:0]        j_cnt;
  logic signed [AW-1:0] acc;

  logic                 wr_ok;
  logic                 ram_we;
  logic [AWA-1:0]       ram_waddr;
  logic signed [WW-1:0] ram_wdata;
  logic signed [WW-1:0] w_cur;
  logic [DW-1:0]        x_cur;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] acc_sh;
  logic [DW-1:0]        y;
  logic [N_OUT*DW-1:0]  res_pack;

  assign state = st;

  // Galois LFSR, x^16+x^14+x^13+x^11+1
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // Host writes outside the weight array are dropped.
  assign wr_ok     = ({1'b0, wr_addr} < (AWA+1)'(NW));
  assign ram_we    = !Rst && ((st == S_INIT) || (st == S_IDLE && wr_en && wr_ok));
  assign ram_waddr = (st == S_INIT) ? w_addr : wr_addr;
  assign ram_wdata = (st == S_INIT) ? $signed(lfsr[WW-1:0]) : wr_data;

  // Weight RAM has no reset; contents survive Rst.
  always_ff @(posedge Clock) begin
    if (ram_we) wram[ram_waddr] <= ram_wdata;
  end

  // MAC walks the weights in storage order, so w_addr doubles as read address.
  assign w_cur  = wram[w_addr];
  assign x_cur  = in_reg[i_cnt];
  assign prod   = AW'($signed({1'b0, x_cur})) * AW'(w_cur);
  assign acc_sh = acc >>> FRAC;

  always_comb begin
    y = '0;
    if (ACT == 0) begin
      if (acc_sh[AW-1])
        y = '0;
      else if (acc_sh > $signed({{(AW-DW){1'b0}}, Y_MAX}))
        y = Y_MAX;
      else
        y = acc_sh[DW-1:0];
    end else begin
      y = (!acc[AW-1] && (acc != '0)) ? Y_MAX : '0;
    end
  end

  // Result buffer with the neuron being stored merged in, so the last
  // neuron reaches out_flat on the same edge it is computed.
  always_comb begin
    res_pack = '0;
    for (int k = 0; k < N_OUT; k++)
      res_pack[k*DW +: DW] = (JW'(k) == j_cnt) ? y : res_buf[k];
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      st            <= S_IDLE;
      out_flat      <= '0;
      Valid         <= 1'b0;
      Busy          <= 1'b0;
      weights_valid <= 1'b0;
      lfsr          <= SEED;
      w_addr        <= '0;
      i_cnt         <= '0;
      j_cnt         <= '0;
      acc           <= '0;
      for (int k = 0; k < N_OUT; k++) res_buf[k] <= '0;
    end else begin
      Valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (Start) begin
            for (int k = 0; k < N_IN; k++) in_reg[k] <= in_flat[k*DW +: DW];
            w_addr <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
            Busy   <= 1'b1;
            st     <= (Init || !weights_valid) ? S_INIT : S_MAC;
          end
        end
        S_INIT: begin
          lfsr <= lfsr_next;
          if (w_addr == AWA'(NW-1)) begin
            weights_valid <= 1'b1;
            w_addr        <= '0;
            st            <= S_MAC;
          end else begin
            w_addr <= w_addr + AWA'(1);
          end
        end
        S_MAC: begin
          acc    <= (i_cnt == '0) ? prod : acc + prod;
          w_addr <= w_addr + AWA'(1);
          if (i_cnt == IW'(N_IN-1)) begin
            i_cnt <= '0;
            st    <= S_STORE;
          end else begin
            i_cnt <= i_cnt + IW'(1);
          end
        end
        S_STORE: begin
          res_buf[j_cnt] <= y;
          if (j_cnt == JW'(N_OUT-1)) begin
            j_cnt    <= '0;
            out_flat <= res_pack;
            Valid    <= 1'b1;
            st       <= S_DONE;
          end else begin
            j_cnt <= j_cnt + JW'(1);
            st    <= S_MAC;
          end
        end
        S_DONE: begin
          Busy <= 1'b0;
          st   <= S_IDLE;
        end
        default: begin
          Busy <= 1'b0;
          st   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ann_layer_engine.sv
// tb_ann_layer_engine
// Two engines share all inputs: dut0 uses ReLU/saturate, dut1 uses threshold.
// A reference model holds the weight array as plain integers. It fills the
// array from the LFSR rule and computes each neuron with integer sums.
module tb_ann_layer_engine;
  localparam int N_IN  = 30;
  localparam int N_OUT = 5;
  localparam int DW    = 10;
  localparam int WW    = 8;
  localparam int FRAC  = 7;
  localparam int NW    = N_IN * N_OUT;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                 Clock = 1'b0;
  logic                 Rst, Start, Init, wr_en;
  logic [N_IN*DW-1:0]   in_flat;
  logic [7:0]           wr_addr;
  logic [WW-1:0]        wr_data;
  logic [N_OUT*DW-1:0]  out0, out1;
  logic                 Valid0, Valid1, Busy0, Busy1;
  logic [2:0]           state0, state1;

  ann_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .FRAC(FRAC),
                     .SEED(SEED), .ACT(0)) dut0 (
    .Clock(Clock), .Rst(Rst), .Start(Start), .Init(Init), .in_flat(in_flat),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_flat(out0), .Valid(Valid0), .Busy(Busy0), .state(state0));

  ann_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .FRAC(FRAC),
                     .SEED(SEED), .ACT(1)) dut1 (
    .Clock(Clock), .Rst(Rst), .Start(Start), .Init(Init), .in_flat(in_flat),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_flat(out1), .Valid(Valid1), .Busy(Busy1), .state(state1));

  always #5 Clock = ~Clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wm [NW];
  int          in_m [N_IN];
  logic [15:0] lfsr_m;
  bit          wv_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    lfsr_m = SEED;
    wv_m   = 1'b0;
  endtask

  task automatic model_init();
    logic signed [7:0] b;
    for (int k = 0; k < NW; k++) begin
      b     = lfsr_m[7:0];
      wm[k] = int'(b);
      lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end
  endtask

  function automatic logic [N_OUT*DW-1:0] model_out(input bit thr);
    logic [N_OUT*DW-1:0] r;
    longint acc, y;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++)
        acc += longint'(in_m[i]) * longint'(wm[j*N_IN + i]);
      y = acc >>> FRAC;
      if (thr)         r[j*DW +: DW] = (acc > 0) ? 10'd1023 : 10'd0;
      else if (y < 0)  r[j*DW +: DW] = 10'd0;
      else if (y > 1023) r[j*DW +: DW] = 10'd1023;
      else             r[j*DW +: DW] = DW'(y);
    end
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N_IN; i++) in_flat[i*DW +: DW] = DW'(in_m[i]);
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N_IN; i++) in_flat[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N_IN; i++) in_m[i] = int'($urandom_range(0, 1023));
  endtask

  task automatic do_reset();
    Rst = 1'b1; Start = 1'b0; wr_en = 1'b0; Init = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Rst = 1'b0;
    model_reset();
  endtask

  task automatic host_wr(input int a, input int d);
    logic signed [7:0] b;
    b = 8'(d);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = b;
    @(posedge Clock); #1;
    wr_en = 1'b0;
    wm[a] = int'(b);
  endtask

  task automatic run_eval(input string tag, input bit init_b, input bit do_wr,
                          input int wa, input int wd, input int disturb_at, input int abort_at);
    logic [N_OUT*DW-1:0] e0, e1, prev;
    logic signed [7:0]   b;
    int exp_lat, exp_init, cyc, n_init, busy_bad, out_chg;
    bit need_init;
    if (do_wr) begin b = 8'(wd); wm[wa] = int'(b); end
    need_init = init_b || !wv_m;
    if (need_init) begin model_init(); wv_m = 1'b1; end
    exp_lat  = need_init ? 1 + NW + N_OUT*(N_IN+1) : 1 + N_OUT*(N_IN+1);
    exp_init = need_init ? NW : 0;
    e0 = model_out(1'b0);
    e1 = model_out(1'b1);

    drive_inputs();
    Init = init_b; Start = 1'b1;
    if (do_wr) begin wr_en = 1'b1; wr_addr = 8'(wa); wr_data = b; end
    @(posedge Clock); #1;
    Start = 1'b0; Init = 1'b0; wr_en = 1'b0;
    scramble_inputs();

    prev = out0; cyc = 1; n_init = 0; busy_bad = 0; out_chg = 0;
    while (!Valid0 && cyc < 400 && cyc != abort_at) begin
      if (state0 == 3'd1) n_init++;
      if (!Busy0) busy_bad++;
      if (out0 !== prev) out_chg++;
      if (cyc == disturb_at) begin
        Start = 1'b1; Init = 1'b1; wr_en = 1'b1;
        wr_addr = 8'(NW-1); wr_data = ~8'(wm[NW-1]);
      end else if (cyc == disturb_at + 1) begin
        Start = 1'b0; Init = 1'b0; wr_en = 1'b0;
      end
      @(posedge Clock); #1;
      cyc++;
    end

    if (abort_at > 0) begin
      chk({tag, " abort_cycle"}, 64'(cyc), 64'(abort_at));
      chk({tag, " state_at_abort"}, 64'(state0), 64'd2);
      Rst = 1'b1;
      @(posedge Clock); #1;
      chk({tag, " rst_out"}, 64'(out0), 64'd0);
      chk({tag, " rst_valid"}, 64'(Valid0), 64'd0);
      chk({tag, " rst_busy"}, 64'(Busy0), 64'd0);
      chk({tag, " rst_state"}, 64'(state0), 64'd0);
      chk({tag, " rst_out_thr"}, 64'(out1), 64'd0);
      Rst = 1'b0;
      model_reset();
      return;
    end

    chk({tag, " valid_seen"}, 64'(Valid0), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " init_cycles"}, 64'(n_init), 64'(exp_init));
    chk({tag, " busy_gaps"}, 64'(busy_bad), 64'd0);
    chk({tag, " out_early_change"}, 64'(out_chg), 64'd0);
    chk({tag, " out_relu"}, 64'(out0), 64'(e0));
    chk({tag, " valid_thr"}, 64'(Valid1), 64'd1);
    chk({tag, " out_thr"}, 64'(out1), 64'(e1));
    @(posedge Clock); #1;
    chk({tag, " valid_pulse"}, 64'(Valid0), 64'd0);
    chk({tag, " idle_busy"}, 64'({Busy1, Busy0}), 64'd0);
    chk({tag, " idle_state"}, 64'({state1, state0}), 64'd0);
    chk({tag, " out_hold"}, 64'(out0), 64'(e0));
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Init = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; in_flat = '0;
    for (int k = 0; k < NW; k++) wm[k] = 0;
    do_reset();
    chk("reset_state", 64'(state0), 64'd0);
    chk("reset_out", 64'(out0), 64'd0);
    chk("reset_valid", 64'(Valid0), 64'd0);
    chk("reset_busy", 64'(Busy0), 64'd0);

    // first Start after reset must initialise weights
    rand_inputs();
    run_eval("t1", 1'b0, 1'b0, 0, 0, -1, -1);
    do_reset();
    run_eval("t1_rerun", 1'b0, 1'b0, 0, 0, -1, -1);

    // host-written weights
    for (int i = 0; i < N_IN; i++) begin
      host_wr(i, 64);
      host_wr(N_IN + i, -64);
      host_wr(2*N_IN + i, (i == 0) ? 127 : 0);
    end
    for (int i = 0; i < N_IN; i++) in_m[i] = 10;
    in_m[0] = 1023;
    run_eval("t2", 1'b0, 1'b0, 0, 0, -1, -1);
    chk("t2 n0", 64'(out0[0 +: DW]), 64'd656);
    chk("t2 n1_clamp", 64'(out0[DW +: DW]), 64'd0);
    chk("t2 n2", 64'(out0[2*DW +: DW]), 64'd1015);

    for (int i = 0; i < N_IN; i++) in_m[i] = 10;
    run_eval("t3a", 1'b0, 1'b0, 0, 0, -1, -1);
    chk("t3a n0", 64'(out0[0 +: DW]), 64'd150);
    for (int i = 0; i < N_IN; i++) in_m[i] = 284;
    run_eval("t3b", 1'b0, 1'b0, 0, 0, -1, -1);
    chk("t3b n0_sat", 64'(out0[0 +: DW]), 64'd1023);

    // threshold activation on neuron 0
    for (int i = 0; i < N_IN; i++) in_m[i] = int'($urandom_range(1, 1023));
    for (int i = 0; i < N_IN; i++) host_wr(i, -1);
    run_eval("t4a", 1'b0, 1'b0, 0, 0, -1, -1);
    chk("t4a thr_n0", 64'(out1[0 +: DW]), 64'd0);
    for (int i = 0; i < N_IN; i++) host_wr(i, 1);
    run_eval("t4b", 1'b0, 1'b0, 0, 0, -1, -1);
    chk("t4b thr_n0", 64'(out1[0 +: DW]), 64'd1023);

    // Start/Init/wr_en during MAC must be ignored
    rand_inputs();
    in_m[N_IN-1] = 1023;
    run_eval("t5", 1'b0, 1'b0, 0, 0, 50, -1);
    run_eval("t5_after", 1'b0, 1'b0, 0, 0, -1, -1);

    // reset mid-MAC, then INIT reruns from the seed
    rand_inputs();
    run_eval("t6", 1'b0, 1'b0, 0, 0, -1, 80);
    run_eval("t6_after", 1'b0, 1'b0, 0, 0, -1, -1);

    // forced re-initialisation continues the LFSR sequence
    rand_inputs();
    run_eval("t7_init", 1'b1, 1'b0, 0, 0, -1, -1);

    // random traffic, some writes coincident with Start
    for (int r = 0; r < 6; r++) begin
      rand_inputs();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        host_wr(int'($urandom_range(0, NW-1)), int'($urandom_range(0, 255)));
      run_eval($sformatf("rnd%0d", r), 1'b0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, NW-1)), int'($urandom_range(0, 255)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
